// File: rtl/bit_serializer_pkg.sv
// ---------------------------------------------------------------------------
// bit_serializer_pkg: FSM state type and counter width helper.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bit_serializer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } ser_state_t;

  function automatic int cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_serializer_hold_buf.sv
// ---------------------------------------------------------------------------
// ser_hold_buf: one-entry valid/ready holding register in front of the shifter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ser_hold_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid_i,
  output logic              push_ready_o,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              w_push;

  // Held low during reset so nothing is accepted while the pipeline is cleared.
  assign push_ready_o = !full_q && !reset;
  assign w_push       = push_valid_i && push_ready_o;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (w_push) begin
      full_d = 1'b1;
      data_d = push_data_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

`default_nettype wire

// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer: parallel word to serial bit stream with a one-word buffer.
// Optional macro SER_PARITY_EN appends an even-parity bit to every word.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   DATA_W   = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              cfg_msb_first_i,
  input  logic              bit_en_i,
  output logic              ser_out_o,
  output logic              ser_valid_o,
  output logic              word_done_o,
  output logic              busy_o
);

  localparam int CNT_W = cnt_w(DATA_W);

  ser_state_t        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              msb_q, msb_d;
`ifdef SER_PARITY_EN
  logic              par_q, par_d;
`endif

  logic              w_buf_full;
  logic [DATA_W-1:0] w_buf_data;
  logic              w_load;
  logic              w_done;
  logic              w_last;
  logic              w_ser;

  ser_hold_buf #(
    .DATA_W (DATA_W)
  ) u_hold_buf (
    .clk          (clk),
    .reset        (reset),
    .push_valid_i (s_valid_i),
    .push_ready_o (s_ready_o),
    .push_data_i  (s_data_i),
    .pop_i        (w_load),
    .data_o       (w_buf_data),
    .full_o       (w_buf_full)
  );

  assign w_last = (cnt_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    msb_d   = msb_q;
`ifdef SER_PARITY_EN
    par_d   = par_q;
`endif
    w_load  = 1'b0;
    w_done  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_buf_full) w_load = 1'b1;
      end
      S_SHIFT: begin
        if (bit_en_i) begin
          if (w_last) begin
`ifdef SER_PARITY_EN
            state_d = S_PARITY;
`else
            w_done = 1'b1;
            if (w_buf_full) w_load = 1'b1;
            else            state_d = S_IDLE;
`endif
          end else begin
            shreg_d = msb_q ? {shreg_q[DATA_W-2:0], 1'b0} : {1'b0, shreg_q[DATA_W-1:1]};
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end
      end
`ifdef SER_PARITY_EN
      S_PARITY: begin
        if (bit_en_i) begin
          w_done = 1'b1;
          if (w_buf_full) w_load = 1'b1;
          else            state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // A reload overrides the end-of-word transition so the next word follows with no gap.
    if (w_load) begin
      state_d = S_SHIFT;
      shreg_d = w_buf_data;
      cnt_d   = CNT_W'(DATA_W);
      msb_d   = cfg_msb_first_i;
`ifdef SER_PARITY_EN
      par_d   = ^w_buf_data;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      msb_q   <= 1'b0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      msb_q   <= msb_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    w_ser = IDLE_BIT;
    case (state_q)
      S_SHIFT:  w_ser = msb_q ? shreg_q[DATA_W-1] : shreg_q[0];
`ifdef SER_PARITY_EN
      S_PARITY: w_ser = par_q;
`endif
      default:  w_ser = IDLE_BIT;
    endcase
  end

  assign ser_out_o   = w_ser;
  assign ser_valid_o = (state_q != S_IDLE);
  assign word_done_o = w_done;
  assign busy_o      = (state_q != S_IDLE) || w_buf_full;

endmodule

`default_nettype wire

// File: tb/tb_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_bit_serializer: directed vectors, corner sequences and random traffic.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bit_serializer;

  localparam int   DATA_W   = 8;
  localparam logic IDLE_BIT = 1'b0;
`ifdef SER_PARITY_EN
  localparam int   BPW      = DATA_W + 1;
`else
  localparam int   BPW      = DATA_W;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              cfg_msb = 1'b1;
  logic              bit_en = 1'b1;
  logic              ser_out, ser_valid, word_done, busy;

  always #5 clk = ~clk;

  bit_serializer #(
    .DATA_W   (DATA_W),
    .IDLE_BIT (IDLE_BIT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .s_valid_i       (s_valid),
    .s_ready_o       (s_ready),
    .s_data_i        (s_data),
    .cfg_msb_first_i (cfg_msb),
    .bit_en_i        (bit_en),
    .ser_out_o       (ser_out),
    .ser_valid_o     (ser_valid),
    .word_done_o     (word_done),
    .busy_o          (busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       msb;
    logic [7:0] exp_bits;   // first bit out at [7]
    logic       exp_par;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          be_mode = 0;  // 0: always, 1: random, N>1: every Nth cycle
  bit          gap_en  = 1'b0;
  logic [7:0]  tx_q[$];
  logic [7:0]  acc_q[$];
  int          acc_cyc[$];
  logic        rx_q[$];
  int          rx_cyc[$];
  int          done_cyc[$];
  logic        exp_q[$];
  logic        rdy_log[int];
  int          bitcnt = 0;
  logic        prev_v = 1'b0, prev_be = 1'b0, prev_out = 1'b0;
  vec_t        tbl[9];
  logic [7:0]  got;
  int          n, errs, ones, a2, d1;
  bit          flipped;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe at the falling edge, then drive just after the rising edge.
  task automatic tick();
    bit acc;
    @(negedge clk);
    rdy_log[cyc] = s_ready;
    if (reset) begin
      bitcnt = 0;
      prev_v = 1'b0;
    end else begin
      if (prev_v && ser_valid && !prev_be) chk("hold_stable", ser_out, prev_out);
      if (!ser_valid) chk("idle_level", ser_out, IDLE_BIT);
      if (ser_valid && bit_en) begin
        rx_q.push_back(ser_out);
        rx_cyc.push_back(cyc);
        bitcnt++;
      end
      if (word_done) begin
        done_cyc.push_back(cyc);
        chk("done_position", bitcnt, BPW);
        bitcnt = 0;
      end
      prev_v   = ser_valid;
      prev_be  = bit_en;
      prev_out = ser_out;
    end
    acc = s_valid && s_ready;
    if (acc) begin
      acc_q.push_back(s_data);
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (acc) void'(tx_q.pop_front());
    s_valid = (tx_q.size() > 0) && (!gap_en || ($urandom_range(0, 3) != 0));
    s_data  = s_valid ? tx_q[0] : 8'($urandom);
    if (be_mode == 0)      bit_en = 1'b1;
    else if (be_mode == 1) bit_en = 1'($urandom_range(0, 1));
    else                   bit_en = ((cyc % be_mode) == 0);
  endtask

  task automatic clear_logs();
    acc_q.delete(); acc_cyc.delete(); rx_q.delete(); rx_cyc.delete();
    done_cyc.delete(); exp_q.delete(); rdy_log.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!(tx_q.size() == 0 && !busy) && k < budget);
    chk({name, "_drained"}, (tx_q.size() == 0 && !busy), 1);
  endtask

  // Reference: a word leaves as DATA_W bits in the chosen order, then its XOR if parity is on.
  task automatic model_word(input logic [7:0] w, input logic msb);
    for (int i = 0; i < DATA_W; i++) exp_q.push_back(msb ? w[DATA_W-1-i] : w[i]);
`ifdef SER_PARITY_EN
    exp_q.push_back(^w);
`endif
  endtask

  task automatic chk_word(input string name, input int base, input logic [7:0] exp);
    logic [7:0] g;
    g = '0;
    for (int i = 0; i < 8; i++) if (base + i < rx_q.size()) g[7-i] = rx_q[base+i];
    chk(name, g, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 8'b10100101, 1'b0};
    tbl[1] = '{8'h05, 1'b0, 8'b10100000, 1'b0};
    tbl[2] = '{8'hA0, 1'b0, 8'b00000101, 1'b0};
    tbl[3] = '{8'hF0, 1'b1, 8'b11110000, 1'b0};
    tbl[4] = '{8'h0F, 1'b0, 8'b11110000, 1'b0};
    tbl[5] = '{8'h3C, 1'b1, 8'b00111100, 1'b0};
    tbl[6] = '{8'h81, 1'b0, 8'b10000001, 1'b0};
    tbl[7] = '{8'h07, 1'b1, 8'b00000111, 1'b1};
    tbl[8] = '{8'h07, 1'b0, 8'b11100000, 1'b1};

    // Reset state, then release
    repeat (3) tick();
    chk("rst_ready", s_ready, 0);
    chk("rst_valid", ser_valid, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    #1;
    chk("rel_ready", s_ready, 1);
    chk("rel_valid", ser_valid, 0);
    chk("rel_out", ser_out, IDLE_BIT);
    chk("rel_busy", busy, 0);
    chk("rel_done", word_done, 0);

    // Directed single words; order flips mid-word must not matter
    for (int k = 0; k < 9; k++) begin
      clear_logs();
      be_mode = 0; gap_en = 1'b0;
      cfg_msb = tbl[k].msb;
      tx_q.push_back(tbl[k].data);
      flipped = 1'b0;
      n = 0;
      while (done_cyc.size() == 0 && n < 40) begin
        tick();
        n++;
        if (rx_q.size() >= 1 && !flipped) begin
          cfg_msb = ~cfg_msb;
          flipped = 1'b1;
        end
      end
      wait_idle("tbl", 10);
      chk("tbl_nbits", rx_q.size(), BPW);
      if (rx_q.size() == BPW && acc_cyc.size() == 1 && done_cyc.size() == 1) begin
        got = '0;
        for (int i = 0; i < 8; i++) got[7-i] = rx_q[i];
        chk("tbl_bits", got, tbl[k].exp_bits);
`ifdef SER_PARITY_EN
        chk("tbl_parity", rx_q[DATA_W], tbl[k].exp_par);
`endif
        chk("tbl_latency", rx_cyc[0] - acc_cyc[0], 2);
        chk("tbl_contig", rx_cyc[BPW-1] - rx_cyc[0], BPW - 1);
        chk("tbl_done_cycle", done_cyc[0], rx_cyc[BPW-1]);
      end
    end

    // Back-to-back words, LSB first, no idle bit between them
    clear_logs();
    cfg_msb = 1'b0;
    tx_q.push_back(8'h05);
    tx_q.push_back(8'hA0);
    wait_idle("b2b", 60);
    chk("b2b_nbits", rx_q.size(), 2 * BPW);
    chk_word("b2b_word0", 0, 8'b10100000);
    chk_word("b2b_word1", BPW, 8'b00000101);
    if (rx_cyc.size() == 2 * BPW) chk("b2b_contig", rx_cyc[2*BPW-1] - rx_cyc[0], 2 * BPW - 1);
    chk("b2b_done_count", done_cyc.size(), 2);

    // bit_en every 4th cycle
    clear_logs();
    be_mode = 4;
    cfg_msb = 1'b1;
    tx_q.push_back(8'hF0);
    tx_q.push_back(8'h0F);
    wait_idle("slow", 200);
    chk("slow_nbits", rx_q.size(), 2 * BPW);
    chk_word("slow_word0", 0, 8'b11110000);
    chk_word("slow_word1", BPW, 8'b00001111);
    errs = 0;
    for (int i = 1; i < rx_cyc.size(); i++) if (rx_cyc[i] - rx_cyc[i-1] != 4) errs++;
    chk("slow_spacing", errs, 0);
    if (acc_cyc.size() == 2 && done_cyc.size() == 2) begin
      a2 = acc_cyc[1];
      d1 = done_cyc[0];
      ones = 0;
      for (int c = a2 + 1; c <= d1; c++) if (rdy_log.exists(c) && rdy_log[c]) ones++;
      chk("slow_ready_low", ones, 0);
      chk("slow_ready_after", rdy_log.exists(d1 + 1) ? rdy_log[d1+1] : 1'b0, 1);
    end else begin
      chk("slow_handshakes", acc_cyc.size() * 10 + done_cyc.size(), 22);
    end

    // Reset during bit 3 with a second word buffered
    clear_logs();
    be_mode = 0;
    cfg_msb = 1'b1;
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h3C);
    n = 0;
    while (rx_q.size() < 3 && n < 40) begin
      tick();
      n++;
    end
    chk("rst_mid_reached", rx_q.size(), 3);
    chk("rst_mid_buffered", s_ready, 0);
    reset = 1'b1;
    s_valid = 1'b0;
    tx_q.delete();
    #1;
    chk("rst_mid_valid", ser_valid, 0);
    chk("rst_mid_out", ser_out, IDLE_BIT);
    chk("rst_mid_busy", busy, 0);
    repeat (2) tick();
    reset = 1'b0;
    clear_logs();
    repeat (6) tick();
    chk("rst_no_residual", rx_q.size(), 0);
    chk("rst_idle_busy", busy, 0);
    cfg_msb = 1'b0;
    tx_q.push_back(8'h81);
    wait_idle("rst_next", 40);
    chk("rst_next_nbits", rx_q.size(), BPW);
    chk_word("rst_next_word", 0, 8'b10000001);

    // Random traffic against the reference model
    for (int b = 0; b < 4; b++) begin
      clear_logs();
      cfg_msb = 1'(b % 2);
      be_mode = (b < 2) ? 1 : 0;
      gap_en  = 1'b1;
      for (int i = 0; i < 25; i++) tx_q.push_back(8'($urandom));
      wait_idle("rnd", 3000);
      for (int i = 0; i < acc_q.size(); i++) model_word(acc_q[i], cfg_msb);
      chk("rnd_accepted", acc_q.size(), 25);
      chk("rnd_nbits", rx_q.size(), exp_q.size());
      errs = 0;
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) if (rx_q[i] !== exp_q[i]) errs++;
      chk("rnd_stream", errs, 0);
      chk("rnd_words", done_cyc.size(), 25);
    end
    gap_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
